mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the core's data-memory request protocol. It accepts level-held read/write requests (`mem_read_en` / `mem_write_en` with `mem_addr` / `mem_write_val`) from the data-memory initiator. It services each request from an internal word array after a programmable latency, then returns `mem_read_val` with a single-cycle `mem_response` pulse. It sits between the data-memory port and the (simulated or on-chip) backing store, and gives the initiator a deterministic, latency-configurable target.

## Interface
- `MEM_WIDTH`, 32, data word width in bits.
- `MEM_DEPTH`, 256, number of words; power of two; `AW = $clog2(MEM_DEPTH)`.
- `LATENCY`, 2, cycles from request acceptance to the `mem_response` pulse; legal range 1..15.

- `clk` input 1: single clock, all logic on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `mem_addr` input 32: word address; only bits `[AW-1:0]` index the array.
- `mem_read_en` input 1: read request, held high by the initiator until it sees the response.
- `mem_write_en` input 1: write request, held high by the initiator until it sees the response.
- `mem_write_val` input MEM_WIDTH: write data, sampled at acceptance.
- `mem_read_val` output MEM_WIDTH: read data; valid from the response cycle and held until the next read response.
- `mem_response` output 1: one-cycle completion pulse.
- `mem_error` output 1: high only in the response cycle, when the request was rejected.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, BUSY, RESPOND, RELEASE.
- **IDLE:** at an edge where `mem_read_en | mem_write_en` is high:
  - latch the address, write data and op;
  - load `cnt = LATENCY-1`;
  - go to RESPOND if `LATENCY==1`, otherwise to BUSY.
- **BUSY:** decrement `cnt` each cycle. At the edge where `cnt==1`, commit the op and go to RESPOND.
- **Commit** happens at the edge entering RESPOND:
  - **write:** `array[idx] <= wdata`.
  - **read:** `mem_read_val <= array[idx]`.
  - **error:** `mem_read_val <= 0` and the array is untouched.
- **Error conditions:**
  - latched address bits `[31:AW]` are nonzero (out of range);
  - both enables were high at acceptance.
- **RESPOND:**
  - `mem_response=1` and `mem_error` is set per the latched error flag, for exactly one cycle;
  - the next state is always RELEASE.
- **RELEASE:**
  - stay while either enable is high, because the initiator drops its enable after seeing the response;
  - go to IDLE on the first edge where both enables are low;
  - this prevents re-servicing a still-held request.
- Input changes during BUSY, RESPOND or RELEASE are ignored. Only the values latched at acceptance matter.
- Array contents are not reset. Simulation init is all zeros.

## Timing
- **Reset values:** `mem_read_val=0`, `mem_response=0`, `mem_error=0`, `busy=0`, state IDLE, `cnt=0`.
- **Reset mid-operation:**
  - the FSM returns to IDLE with no response;
  - an uncommitted write is dropped;
  - a write already committed stays.
- **Latency:** acceptance at edge E0. `mem_response` is high in the cycle after edge E0+LATENCY-1, i.e. it is first visible LATENCY cycles after E0.
- **Pulse width:** `mem_response` is exactly 1 cycle and is never asserted on consecutive cycles.
- **Minimum spacing:** at least LATENCY+2 cycles between acceptances (a response, at least one RELEASE cycle, then IDLE).
- **Back-to-back requests:** a new request raised in the RELEASE→IDLE cycle is accepted at the next edge in IDLE.
- `busy` rises the cycle after acceptance and falls on entry to IDLE.

## Structure
- **Package `mem_pkg`:**
  - state enum (IDLE, BUSY, RESPOND, RELEASE);
  - op encoding (OP_READ, OP_WRITE);
  - `LAT_W = 4` counter width constant.
- **Sub-module `mem_array`:**
  - parameterised by MEM_WIDTH and MEM_DEPTH;
  - synchronous write, registered read, one shared port;
  - enables driven by the FSM commit strobe.
- The top level holds the FSM, latency counter, request latches and error logic.

## Test plan
- **Write then read, LATENCY=2:**
  - write 0xDEADBEEF to address 0x10: `mem_response` pulses 2 cycles after acceptance, `mem_error=0`;
  - read of 0x10: `mem_read_val=0xDEADBEEF` with the pulse.
- **LATENCY=1 and LATENCY=15:** read of address 0x03 responds 1 and 15 cycles after acceptance respectively; the pulse is always 1 cycle wide.
- **Held enable:** initiator keeps `mem_read_en` high for 10 cycles after the response. Exactly one pulse occurs, and the FSM stays in RELEASE until the enable drops.
- **Out of range:** write 0x12345678 to 0x100 (DEPTH=256). Expected: `mem_error=1` with the response, `array[0x00]` is unchanged, and a subsequent read of 0x100 returns 0 with `mem_error=1`.
- **Both enables high:** error response, no array write, `mem_read_val=0`.
- **Reset in BUSY:**
  - write 0xAAAA5555 to 0x20 with LATENCY=4;
  - assert `rst_n=0` one cycle after acceptance;
  - expected: no response pulse, all outputs zero;
  - a subsequent read of 0x20 returns the prior contents (0).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_t : responder FSM states
//   op_t    : latched request operation
//   LAT_W   : latency counter width (covers LATENCY 1..15)
package mem_pkg;

  localparam int unsigned LAT_W  = 4;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // True when any address bit above the array index range is set.
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr,
                                             input int unsigned       aw);
    return (addr >> aw) != '0;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array: synchronous write, registered read.
//   clk, rst_n : clock, synchronous active-low reset (read register only)
//   en, we     : access strobe and write select
//   rd_clr     : clears the read register (error completion)
//   addr       : word index
//   wdata      : write data
//   rdata      : registered read data, held between reads
module mem_array #(
  parameter  int unsigned MEM_WIDTH = 32,
  parameter  int unsigned MEM_DEPTH = 256,
  localparam int unsigned AW        = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 we,
  input  logic                 rd_clr,
  input  logic [AW-1:0]        addr,
  input  logic [MEM_WIDTH-1:0] wdata,
  output logic [MEM_WIDTH-1:0] rdata
);

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register; only read commits and error commits update it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: accepts a level-held read/write request, services it
// from an internal array after LATENCY cycles and returns a one-cycle response.
//   clk, rst_n    : clock, synchronous active-low reset
//   mem_addr      : word address (upper bits beyond the array flag an error)
//   mem_read_en   : read request, held until the response is seen
//   mem_write_en  : write request, held until the response is seen
//   mem_write_val : write data, sampled at acceptance
//   mem_read_val  : read data, held until the next read/error response
//   mem_response  : one-cycle completion pulse
//   mem_error     : rejected request, valid with mem_response
//   busy          : high whenever the FSM is not idle
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_read_en,
  input  logic                 mem_write_en,
  input  logic [MEM_WIDTH-1:0] mem_write_val,
  output logic [MEM_WIDTH-1:0] mem_read_val,
  output logic                 mem_response,
  output logic                 mem_error,
  output logic                 busy
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  state_t               state, state_nxt;
  logic [LAT_W-1:0]     cnt, cnt_nxt;

  // Request latches
  op_t                  op_q;
  logic                 err_q;
  logic [AW-1:0]        idx_q;
  logic [MEM_WIDTH-1:0] wdata_q;

  logic                 req_c;
  logic                 commit_c;
  logic                 in_err_c;
  op_t                  in_op_c;

  // Commit-side request view
  logic                 c_err;
  op_t                  c_op;
  logic [AW-1:0]        c_idx;
  logic [MEM_WIDTH-1:0] c_wdata;

  assign req_c    = mem_read_en | mem_write_en;
  assign in_err_c = addr_out_of_range(mem_addr, AW) | (mem_read_en & mem_write_en);
  assign in_op_c  = mem_write_en ? OP_WRITE : OP_READ;

  // With LATENCY==1 the commit happens at the accepting edge, before the
  // latches hold the request, so the commit reads the live inputs in IDLE.
  always_comb begin
    c_err   = err_q;
    c_op    = op_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    if (state == IDLE) begin
      c_err   = in_err_c;
      c_op    = in_op_c;
      c_idx   = mem_addr[AW-1:0];
      c_wdata = mem_write_val;
    end
  end

  // Next-state, latency countdown and commit strobe.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit_c  = 1'b0;
    case (state)
      IDLE: begin
        if (req_c) begin
          cnt_nxt = LAT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_nxt = RESPOND;
            commit_c  = 1'b1;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - LAT_W'(1);
        if (cnt == LAT_W'(1)) begin
          state_nxt = RESPOND;
          commit_c  = 1'b1;
        end
      end
      RESPOND: begin
        state_nxt = RELEASE;
      end
      RELEASE: begin
        // Wait for the initiator to drop its enable so it is not re-serviced.
        if (!req_c) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM, counter and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      mem_response <= 1'b0;
      mem_error    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      mem_response <= commit_c;
      mem_error    <= commit_c & c_err;
      busy         <= (state_nxt != IDLE);
    end
  end

  // Request capture at acceptance; ignored in every other state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= OP_READ;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req_c) begin
      op_q    <= in_op_c;
      err_q   <= in_err_c;
      idx_q   <= mem_addr[AW-1:0];
      wdata_q <= mem_write_val;
    end
  end

  mem_array #(
    .MEM_WIDTH (MEM_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (commit_c & ~c_err),
    .we     (c_op == OP_WRITE),
    .rd_clr (commit_c & c_err),
    .addr   (c_idx),
    .wdata  (c_wdata),
    .rdata  (mem_read_val)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; four instances cover LATENCY 2, 1, 15, 4.
module tb_mem_responder;

  logic        clk;
  logic        rst_n [4];
  logic        rd_en [4];
  logic        wr_en [4];
  logic [31:0] addr  [4];
  logic [31:0] wval  [4];
  logic [31:0] rval  [4];
  logic        resp  [4];
  logic        err   [4];
  logic        bsy   [4];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_responder #(.MEM_WIDTH(32), .MEM_DEPTH(256), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n[0]), .mem_addr(addr[0]), .mem_read_en(rd_en[0]),
    .mem_write_en(wr_en[0]), .mem_write_val(wval[0]), .mem_read_val(rval[0]),
    .mem_response(resp[0]), .mem_error(err[0]), .busy(bsy[0]));

  mem_responder #(.MEM_WIDTH(32), .MEM_DEPTH(256), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n[1]), .mem_addr(addr[1]), .mem_read_en(rd_en[1]),
    .mem_write_en(wr_en[1]), .mem_write_val(wval[1]), .mem_read_val(rval[1]),
    .mem_response(resp[1]), .mem_error(err[1]), .busy(bsy[1]));

  mem_responder #(.MEM_WIDTH(32), .MEM_DEPTH(256), .LATENCY(15)) u_lat15 (
    .clk(clk), .rst_n(rst_n[2]), .mem_addr(addr[2]), .mem_read_en(rd_en[2]),
    .mem_write_en(wr_en[2]), .mem_write_val(wval[2]), .mem_read_val(rval[2]),
    .mem_response(resp[2]), .mem_error(err[2]), .busy(bsy[2]));

  mem_responder #(.MEM_WIDTH(32), .MEM_DEPTH(256), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n[3]), .mem_addr(addr[3]), .mem_read_en(rd_en[3]),
    .mem_write_en(wr_en[3]), .mem_write_val(wval[3]), .mem_read_val(rval[3]),
    .mem_response(resp[3]), .mem_error(err[3]), .busy(bsy[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request on instance i (called #1 after an edge with the DUT idle),
  // measure latency, check the response, hold the enable for `hold` extra
  // cycles, then release and confirm a single pulse and return to idle.
  task automatic do_req(input int i, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int lat, input int hold,
                        input logic exp_err, input logic [31:0] exp_rval,
                        input string tag);
    int n;
    int extra;
    rd_en[i] = rd;
    wr_en[i] = wr;
    addr[i]  = a;
    wval[i]  = wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        check({tag, ":busy_rise"}, 32'(bsy[i]), 32'd1);
        // Inputs after acceptance must not matter.
        addr[i] = a ^ 32'h0000_0005;
        wval[i] = ~wd;
      end
    end while (!resp[i] && n < 40);
    check({tag, ":latency"}, 32'(n), 32'(lat));
    check({tag, ":error"}, 32'(err[i]), 32'(exp_err));
    check({tag, ":read_val"}, rval[i], exp_rval);
    extra = 0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (resp[i]) extra++;
    end
    if (hold > 0) check({tag, ":held_busy"}, 32'(bsy[i]), 32'd1);
    rd_en[i] = 1'b0;
    wr_en[i] = 1'b0;
    repeat ((hold == 0) ? 2 : 1) begin
      @(posedge clk); #1;
      if (resp[i]) extra++;
    end
    check({tag, ":extra_pulses"}, 32'(extra), 32'd0);
    check({tag, ":busy_fall"}, 32'(bsy[i]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0;
      rd_en[i] = 1'b0;
      wr_en[i] = 1'b0;
      addr[i]  = '0;
      wval[i]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst%0d:read_val", i), rval[i], 32'd0);
      check($sformatf("rst%0d:response", i), 32'(resp[i]), 32'd0);
      check($sformatf("rst%0d:error", i), 32'(err[i]), 32'd0);
      check($sformatf("rst%0d:busy", i), 32'(bsy[i]), 32'd0);
      rst_n[i] = 1'b1;
    end
    @(posedge clk); #1;

    // LATENCY=2: functional sequence
    do_req(0, 0, 1, 32'h10,  32'hDEADBEEF, 2, 0, 0, 32'h0,        "wr10");
    do_req(0, 1, 0, 32'h10,  32'h0,        2, 0, 0, 32'hDEADBEEF, "rd10");
    do_req(0, 1, 0, 32'h10,  32'h0,        2, 10, 0, 32'hDEADBEEF, "rd10_held");
    do_req(0, 0, 1, 32'h100, 32'h12345678, 2, 0, 1, 32'h0,        "wr_oob");
    do_req(0, 1, 0, 32'h00,  32'h0,        2, 0, 0, 32'h0,        "rd00");
    do_req(0, 1, 0, 32'h10,  32'h0,        2, 0, 0, 32'hDEADBEEF, "rd10_again");
    do_req(0, 1, 0, 32'h100, 32'h0,        2, 0, 1, 32'h0,        "rd_oob");
    do_req(0, 1, 0, 32'h10,  32'h0,        2, 0, 0, 32'hDEADBEEF, "rd10_pre_both");
    do_req(0, 1, 1, 32'h10,  32'h11111111, 2, 0, 1, 32'h0,        "both_en");
    do_req(0, 1, 0, 32'h10,  32'h0,        2, 0, 0, 32'hDEADBEEF, "rd10_post_both");
    do_req(0, 0, 1, 32'hFF,  32'h00000055, 2, 0, 0, 32'hDEADBEEF, "wrFF");
    do_req(0, 1, 0, 32'hFF,  32'h0,        2, 0, 0, 32'h00000055, "rdFF");

    // LATENCY=1 and LATENCY=15
    do_req(1, 0, 1, 32'h03, 32'hCAFEF00D, 1, 0, 0, 32'h0,        "l1_wr03");
    do_req(1, 1, 0, 32'h03, 32'h0,        1, 3, 0, 32'hCAFEF00D, "l1_rd03");
    do_req(2, 0, 1, 32'h03, 32'h0BADF00D, 15, 0, 0, 32'h0,       "l15_wr03");
    do_req(2, 1, 0, 32'h03, 32'h0,        15, 0, 0, 32'h0BADF00D, "l15_rd03");

    // LATENCY=4: reset while BUSY drops the uncommitted write
    do_req(3, 0, 1, 32'h30, 32'h5A5A5A5A, 4, 0, 0, 32'h0,        "l4_wr30");
    do_req(3, 1, 0, 32'h30, 32'h0,        4, 0, 0, 32'h5A5A5A5A, "l4_rd30");
    wr_en[3] = 1'b1;
    addr[3]  = 32'h20;
    wval[3]  = 32'hAAAA5555;
    @(posedge clk); #1;
    check("rstbusy:busy_rise", 32'(bsy[3]), 32'd1);
    @(posedge clk); #1;
    rst_n[3] = 1'b0;
    wr_en[3] = 1'b0;
    @(posedge clk); #1;
    check("rstbusy:response", 32'(resp[3]), 32'd0);
    check("rstbusy:error", 32'(err[3]), 32'd0);
    check("rstbusy:busy", 32'(bsy[3]), 32'd0);
    check("rstbusy:read_val", rval[3], 32'd0);
    @(posedge clk); #1;
    check("rstbusy:response_hold", 32'(resp[3]), 32'd0);
    rst_n[3] = 1'b1;
    @(posedge clk); #1;
    check("rstbusy:post_response", 32'(resp[3]), 32'd0);
    do_req(3, 1, 0, 32'h20, 32'h0, 4, 0, 0, 32'h0, "l4_rd20");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
